// File: rtl/leaf_fifo_loader_pkg.sv
// Shared defaults and FSM encoding for the leaf FIFO loader.
// Widths and the terminator value match the merger tree and FIFOs.
package leaf_fifo_loader_pkg;

  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_NUM_LEAVES = 4;
  localparam int unsigned DEF_RUN_LEN    = 4;
  localparam int unsigned DEF_CNT_W      = 16;
  localparam logic [DEF_DATA_W-1:0] DEF_TERMINATOR = '0;

  typedef enum logic {
    S_DATA = 1'b0,
    S_TERM = 1'b1
  } state_e;

endpackage

// File: rtl/leaf_fifo_loader.sv
// Cuts a presorted record stream into terminated runs and
// writes them round-robin into the merger tree leaf FIFOs.
module leaf_fifo_loader
  import leaf_fifo_loader_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned NUM_LEAVES = DEF_NUM_LEAVES,
  parameter int unsigned RUN_LEN    = DEF_RUN_LEN,
  parameter logic [DATA_W-1:0] TERMINATOR = DATA_W'(DEF_TERMINATOR),
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_W-1:0]     i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_flush,
  input  logic [NUM_LEAVES-1:0] i_fifo_full,
  output logic [NUM_LEAVES-1:0] o_fifo_write,
  output logic [DATA_W-1:0]     o_fifo_data,
  output logic [CNT_W-1:0]      o_runs_done,
  output logic                  o_err
);

  localparam int unsigned SW =
    (NUM_LEAVES > 1) ? $clog2(NUM_LEAVES) : 1;
  localparam int unsigned CW = $clog2(RUN_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(RUN_LEN - 1);

  state_e           state_q, state_d;
  logic [SW-1:0]    sel_q, sel_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] runs_q, runs_d;
  logic             err_q, err_d;

  logic             leaf_full;
  logic             accept;
  logic [NUM_LEAVES-1:0] sel_oh;

  assign leaf_full = i_fifo_full[sel_q];
  assign sel_oh    = NUM_LEAVES'(1) << sel_q;

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    cnt_d        = cnt_q;
    runs_d       = runs_q;
    err_d        = err_q;
    accept       = 1'b0;
    o_ready      = 1'b0;
    o_fifo_write = '0;
    o_fifo_data  = i_data;
    unique case (state_q)
      S_DATA: begin
        o_ready = !leaf_full;
        accept  = i_valid && !leaf_full;
        if (accept) begin
          o_fifo_write = sel_oh;
          cnt_d        = cnt_q + CW'(1);
          if (i_data == TERMINATOR) err_d = 1'b1;
          if (cnt_q == LAST || i_flush) begin
            state_d = S_TERM;
            cnt_d   = '0;
          end
        end else if (i_flush && cnt_q != '0) begin
          state_d = S_TERM;
          cnt_d   = '0;
        end
      end
      S_TERM: begin
        // A full leaf stalls everything; the order is never skipped.
        if (!leaf_full) begin
          o_fifo_write = sel_oh;
          o_fifo_data  = TERMINATOR;
          sel_d        = sel_q + SW'(1);
          runs_d       = runs_q + CNT_W'(1);
          state_d      = S_DATA;
        end
      end
      default: state_d = S_DATA;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_DATA;
      sel_q   <= '0;
      cnt_q   <= '0;
      runs_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      runs_q  <= runs_d;
      err_q   <= err_d;
    end
  end

  assign o_runs_done = runs_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_leaf_fifo_loader.sv
// Directed table-driven bench for leaf_fifo_loader
// (RUN_LEN=4, four leaves, 2-bit run counter).
module tb_leaf_fifo_loader;

  logic        clk;
  logic        rst_n;
  logic [31:0] data;
  logic        valid;
  logic        ready;
  logic        flush;
  logic [3:0]  full;
  logic [3:0]  wr;
  logic [31:0] wdata;
  logic [1:0]  runs;
  logic        err;

  int checks = 0;
  int failures = 0;

  leaf_fifo_loader #(
    .DATA_W(32), .NUM_LEAVES(4), .RUN_LEN(4),
    .TERMINATOR(32'd0), .CNT_W(2)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_data(data), .i_valid(valid),
    .o_ready(ready), .i_flush(flush),
    .i_fifo_full(full), .o_fifo_write(wr),
    .o_fifo_data(wdata), .o_runs_done(runs),
    .o_err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] data;
    logic        flush;
    logic [3:0]  full;
    logic        ready;
    logic [3:0]  wr;
    logic [31:0] wdata;
    logic [1:0]  runs;
    logic        err;
  } vec_t;

  vec_t vq[$];

  function automatic void add(
    input logic v, input logic [31:0] d,
    input logic f, input logic [3:0] fu,
    input logic r, input logic [3:0] w,
    input logic [31:0] wd, input logic [1:0] rn,
    input logic e);
    vec_t t;
    t.valid = v; t.data = d; t.flush = f;
    t.full = fu; t.ready = r; t.wr = w;
    t.wdata = wd; t.runs = rn; t.err = e;
    vq.push_back(t);
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    data  = '0;
    valid = 1'b0;
    flush = 1'b0;
    full  = '0;

    // run 0 -> leaf0, run 1 -> leaf1 with a 3-cycle full stall
    add(1, 1, 0, 0, 1, 4'b0001, 1, 0, 0);
    add(1, 2, 0, 0, 1, 4'b0001, 2, 0, 0);
    add(1, 3, 0, 0, 1, 4'b0001, 3, 0, 0);
    add(1, 4, 0, 0, 1, 4'b0001, 4, 0, 0);
    add(1, 5, 0, 0, 0, 4'b0001, 0, 0, 0);
    add(1, 5, 0, 0, 1, 4'b0010, 5, 1, 0);
    add(1, 6, 0, 4'b0010, 0, 0, 0, 1, 0);
    add(1, 6, 0, 4'b0010, 0, 0, 0, 1, 0);
    add(1, 6, 0, 4'b0010, 0, 0, 0, 1, 0);
    add(1, 6, 0, 0, 1, 4'b0010, 6, 1, 0);
    add(1, 7, 0, 0, 1, 4'b0010, 7, 1, 0);
    add(1, 8, 0, 0, 1, 4'b0010, 8, 1, 0);
    add(0, 0, 0, 0, 0, 4'b0010, 0, 1, 0);
    // partial run closed by flush, then empty flush
    add(1, 9, 0, 0, 1, 4'b0100, 9, 2, 0);
    add(1, 10, 0, 0, 1, 4'b0100, 10, 2, 0);
    add(0, 0, 1, 0, 1, 4'b0000, 0, 2, 0);
    add(0, 0, 0, 0, 0, 4'b0100, 0, 2, 0);
    add(0, 0, 1, 0, 1, 4'b0000, 0, 3, 0);
    // flush together with a beat
    add(1, 11, 1, 0, 1, 4'b1000, 11, 3, 0);
    add(0, 0, 0, 0, 0, 4'b1000, 0, 3, 0);
    // 5th run wraps to leaf0; beat 0 sets err
    add(1, 0, 0, 0, 1, 4'b0001, 0, 0, 0);
    add(1, 12, 0, 0, 1, 4'b0001, 12, 0, 1);
    add(1, 13, 0, 0, 1, 4'b0001, 13, 0, 1);
    add(1, 14, 0, 0, 1, 4'b0001, 14, 0, 1);
    add(1, 15, 0, 4'b0001, 0, 0, 0, 0, 1);
    add(1, 15, 0, 0, 0, 4'b0001, 0, 0, 1);
    add(0, 0, 0, 0, 1, 4'b0000, 0, 1, 1);

    // reset state
    #1;
    chk("rst_ready", 32'(ready), 1);
    chk("rst_wr", 32'(wr), 0);
    chk("rst_runs", 32'(runs), 0);
    chk("rst_err", 32'(err), 0);
    full = 4'b0001;
    #1;
    chk("rst_ready_full0", 32'(ready), 0);
    full = '0;

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      if (i > 0) @(negedge clk);
      valid = vq[i].valid;
      data  = vq[i].data;
      flush = vq[i].flush;
      full  = vq[i].full;
      #1;
      chk($sformatf("v%0d_ready", i),
          32'(ready), 32'(vq[i].ready));
      chk($sformatf("v%0d_wr", i),
          32'(wr), 32'(vq[i].wr));
      if (vq[i].wr != 0)
        chk($sformatf("v%0d_data", i),
            wdata, vq[i].wdata);
      chk($sformatf("v%0d_runs", i),
          32'(runs), 32'(vq[i].runs));
      chk($sformatf("v%0d_err", i),
          32'(err), 32'(vq[i].err));
    end

    // async reset mid-run at leaf1 with cnt=2
    @(negedge clk);
    valid = 1'b1; data = 16; flush = 0; full = 0;
    #1 chk("pre_wr16", 32'(wr), 32'b0010);
    @(negedge clk);
    data = 17;
    #1 chk("pre_wr17", 32'(wr), 32'b0010);
    @(negedge clk);
    valid = 1'b0;
    full  = 4'b0001;
    #1 chk("pre_ready", 32'(ready), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_ready", 32'(ready), 0);
    chk("arst_wr", 32'(wr), 0);
    chk("arst_runs", 32'(runs), 0);
    chk("arst_err", 32'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    full  = '0;
    valid = 1'b1;
    data  = 21;
    #1;
    chk("post_wr", 32'(wr), 32'b0001);
    chk("post_data", wdata, 21);
    for (int k = 22; k <= 24; k++) begin
      @(negedge clk);
      data = k;
      #1 chk($sformatf("post_wr%0d", k),
             32'(wr), 32'b0001);
    end
    @(negedge clk);
    valid = 1'b0;
    #1;
    chk("post_term_wr", 32'(wr), 32'b0001);
    chk("post_term_data", wdata, 0);
    @(negedge clk);
    #1;
    chk("post_runs", 32'(runs), 1);
    chk("post_ready", 32'(ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
